// File: rtl/dmux8_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// dmux8_dispatch_pkg
//   Shared definitions for the 8-way dispatch controller: lane count,
//   destination index width and the controller state encoding.
//   No ports (package).
// ---------------------------------------------------------------------------
package dmux8_dispatch_pkg;

    localparam int LANES  = 8;
    localparam int DEST_W = 3;

    // IDLE: nothing held. HOLD: word held and presented on its lane.
    // DROP: one-cycle timeout discard (only reachable with the timeout build).
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_DROP = 2'b10
    } state_t;

endpackage

// File: rtl/dmux8_dispatch_route.sv
// ---------------------------------------------------------------------------
// dmux8_dispatch_route
//   Combinational 1-of-8 steering of the held word and its valid flag onto
//   the lane bus. Only the addressed lane carries data; every other lane is
//   driven to zero, and all lanes are zero when nothing is presented.
// Ports
//   hold       in   1              a word is being presented
//   dest       in   DEST_W         lane index of the held word
//   word       in   WIDTH          held word
//   out_data   out  LANES*WIDTH    lane k = out_data[k*WIDTH +: WIDTH]
//   out_valid  out  LANES          one-hot (or zero) lane valid
// ---------------------------------------------------------------------------
module dmux8_dispatch_route
    import dmux8_dispatch_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    hold,
    input  logic [DEST_W-1:0]       dest,
    input  logic [WIDTH-1:0]        word,
    output logic [LANES*WIDTH-1:0]  out_data,
    output logic [LANES-1:0]        out_valid
);

    always_comb begin
        out_data  = '0;
        out_valid = '0;
        if (hold) begin
            out_valid[dest]                = 1'b1;
            out_data[dest*WIDTH +: WIDTH]  = word;
        end
    end

endmodule

// File: rtl/dmux8_dispatch.sv
// ---------------------------------------------------------------------------
// dmux8_dispatch
//   Sequencing controller for the 16-bit 8-way demux fabric. Accepts one word
//   per cycle from a single producer, holds it in a single-entry register and
//   presents it to one of 8 consumer lanes. The destination is either the
//   addressed input or an internal round-robin pointer.
//
//   Handshake rules: a transfer happens on a rising edge where valid and ready
//   are both high. The producer side transfers on in_valid & in_ready; lane k
//   transfers on out_valid[k] & out_ready[k], except in a cycle with flush=1,
//   where consumers must not sample and the held word is discarded.
//
//   Optional feature (macro DMUX_DISPATCH_TIMEOUT_EN): a word stalled for
//   TIMEOUT consecutive HOLD cycles is dropped through a one-cycle DROP state
//   and counted in drop_count (saturating). Without the macro, HOLD waits
//   indefinitely and drop_count is tied to zero.
//
// Ports
//   clk         in   1          rising-edge clock
//   rst_n       in   1          asynchronous active-low reset
//   in_data     in   WIDTH      word to dispatch
//   in_dest     in   3          destination lane when rr_mode=0
//   in_valid    in   1          producer has a word
//   in_ready    out  1          dispatcher accepts this cycle
//   rr_mode     in   1          1: ignore in_dest, use round-robin pointer
//   flush       in   1          synchronous discard of held word
//   out_data    out  8*WIDTH    lane k = out_data[k*WIDTH +: WIDTH]
//   out_valid   out  8          one-hot (or zero) lane valid
//   out_ready   in   8          per-lane consumer ready
//   busy        out  1          a word is held (state != IDLE)
//   drop_count  out  8          timeout drops, saturating
// ---------------------------------------------------------------------------
module dmux8_dispatch
    import dmux8_dispatch_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [DEST_W-1:0]       in_dest,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    rr_mode,
    input  logic                    flush,
    output logic [LANES*WIDTH-1:0]  out_data,
    output logic [LANES-1:0]        out_valid,
    input  logic [LANES-1:0]        out_ready,
    output logic                    busy,
    output logic [7:0]              drop_count
);

    state_t              state_q;
    state_t              state_d;
    logic [WIDTH-1:0]    held_q;
    logic [DEST_W-1:0]   dest_q;
    logic [DEST_W-1:0]   rr_ptr_q;
    logic [DEST_W-1:0]   dest_sel;
    logic                in_hold;
    logic                lane_ready;
    logic                accept;
    logic                timeout_hit;

    assign in_hold    = (state_q == ST_HOLD);
    assign lane_ready = out_ready[dest_q];
    assign dest_sel   = rr_mode ? rr_ptr_q : in_dest;

    // A new word can be taken when empty, or when the held word leaves on
    // this same edge. rst_n gating keeps in_ready low during reset.
    assign in_ready = rst_n & ~flush & ((state_q == ST_IDLE) | (in_hold & lane_ready));
    assign accept   = in_valid & in_ready;
    assign busy     = (state_q != ST_IDLE);

`ifdef DMUX_DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] hold_cnt_q;
    logic [7:0]       drop_q;
    logic             stall;

    // A stall cycle is a HOLD cycle whose lane is not ready; the counter
    // value equals the number of earlier stall cycles, so the TIMEOUT-th
    // stall cycle is the one that sees TIMEOUT-1.
    assign stall       = in_hold & ~lane_ready;
    assign timeout_hit = stall & (hold_cnt_q == CNT_W'(TIMEOUT - 1));
    assign drop_count  = drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            drop_q     <= '0;
        end else begin
            if (flush || !stall) begin
                hold_cnt_q <= '0;
            end else begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end
            if (timeout_hit && !flush && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end
`else
    logic unused_timeout;

    // Keeps the parameter referenced when the timeout path is compiled out.
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
    assign drop_count     = '0;
`endif

    // Next-state logic: flush wins over everything, then accept, then the
    // lane handshake, then timeout.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (accept)           state_d = ST_HOLD;
                    else if (lane_ready)  state_d = ST_IDLE;
                    else if (timeout_hit) state_d = ST_DROP;
                end
`ifdef DMUX_DISPATCH_TIMEOUT_EN
                ST_DROP: state_d = ST_IDLE;
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            held_q   <= '0;
            dest_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                held_q <= in_data;
                dest_q <= dest_sel;
            end else if (flush) begin
                held_q <= '0;
            end
            // Pointer advances only on words it actually addressed; the
            // 3-bit width gives the 7->0 wrap.
            if (accept && rr_mode) begin
                rr_ptr_q <= rr_ptr_q + 1'b1;
            end
        end
    end

    dmux8_dispatch_route #(
        .WIDTH (WIDTH)
    ) u_route (
        .hold      (in_hold),
        .dest      (dest_q),
        .word      (held_q),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

endmodule

// File: tb/tb_dmux8_dispatch.sv
// ---------------------------------------------------------------------------
// tb_dmux8_dispatch
//   Self-checking bench for dmux8_dispatch. Accepted words are pushed to an
//   expected queue as {lane, data}; a negedge monitor pops one entry per lane
//   handshake. Scenario tasks add inline checks of the control outputs.
//   The timeout scenario follows DMUX_DISPATCH_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_dmux8_dispatch;

    localparam int W = 16;

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   in_data;
    logic [2:0]     in_dest;
    logic           in_valid;
    logic           in_ready;
    logic           rr_mode;
    logic           flush;
    logic [8*W-1:0] out_data;
    logic [7:0]     out_valid;
    logic [7:0]     out_ready;
    logic           busy;
    logic [7:0]     drop_count;

    int errors = 0;
    int checks = 0;

    logic [18:0] exp_q[$];
    logic [2:0]  tb_ptr;

    dmux8_dispatch #(
        .WIDTH   (W),
        .TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rr_mode    (rr_mode),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .drop_count (drop_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    // Presents one word for one cycle, records it as expected and advances
    // the bench's own round-robin model. Caller guarantees acceptance.
    task automatic send(input logic [W-1:0] data, input logic [2:0] dest);
        in_data  = data;
        in_dest  = dest;
        in_valid = 1'b1;
        exp_q.push_back({(rr_mode ? tb_ptr : dest), data});
        if (rr_mode) tb_ptr = tb_ptr + 3'd1;
        tick();
        in_valid = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            checks++;
            if ($countones(out_valid) > 1) begin
                errors++;
                $display("FAIL onehot: out_valid=%b required at most one bit", out_valid);
            end
            for (int k = 0; k < 8; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL lane_xfer: lane=%0d data=%h but no word expected",
                                 k, out_data[k*W +: W]);
                    end else begin
                        logic [18:0] exp;
                        exp = exp_q.pop_front();
                        if ({3'(k), out_data[k*W +: W]} !== exp) begin
                            errors++;
                            $display("FAIL lane_xfer: got lane=%0d data=%h required lane=%0d data=%h",
                                     k, out_data[k*W +: W], exp[18:16], exp[15:0]);
                        end
                    end
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        checks += 5;
        if (out_valid !== 8'h00) begin errors++; $display("FAIL reset_valid: got %h required 00", out_valid); end
        if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h required 0", out_data); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d required 0", drop_count); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [8*W-1:0] mask;
        rr_mode   = 1'b0;
        out_ready = 8'hFF;
        in_data   = 16'hBEEF;
        in_dest   = 3'd5;
        in_valid  = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b required 1", in_ready); end
        exp_q.push_back({3'd5, 16'hBEEF});
        tick();
        in_valid = 1'b0;
        mask = ~({{(7*W){1'b0}}, {W{1'b1}}} << (5*W));
        checks += 4;
        if (out_valid !== 8'h20) begin errors++; $display("FAIL single_valid: got %h required 20", out_valid); end
        if (out_data[5*W +: W] !== 16'hBEEF) begin errors++; $display("FAIL single_lane5: got %h required beef", out_data[5*W +: W]); end
        if ((out_data & mask) !== '0) begin errors++; $display("FAIL single_others: got %h required 0", out_data & mask); end
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b required 1", busy); end
        tick();
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b required 0", busy); end
        if (out_valid !== 8'h00) begin errors++; $display("FAIL single_valid_after: got %h required 00", out_valid); end
    endtask

    task automatic test_back_to_back_rr();
        rr_mode   = 1'b1;
        out_ready = 8'hFF;
        for (int i = 1; i <= 10; i++) begin
            in_data  = W'(i);
            in_dest  = 3'($urandom_range(0, 7));
            in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL rr_in_ready: word %0d got %b required 1", i, in_ready); end
            exp_q.push_back({tb_ptr, W'(i)});
            tb_ptr = tb_ptr + 3'd1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rr_drain: %0d words pending required 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        rr_mode   = 1'b0;
        out_ready = 8'hFB;
        send(16'h1234, 3'd2);
        in_data  = 16'h5678;
        in_dest  = 3'd2;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checks += 3;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: cycle %0d got %b required 0", c, in_ready); end
            if (out_valid !== 8'h04) begin errors++; $display("FAIL stall_valid: cycle %0d got %h required 04", c, out_valid); end
            if (out_data[2*W +: W] !== 16'h1234) begin errors++; $display("FAIL stall_hold: cycle %0d got %h required 1234", c, out_data[2*W +: W]); end
            tick();
        end
        // Lane releases while the next word is offered: both transfers complete.
        out_ready = 8'hFF;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b required 1", in_ready); end
        exp_q.push_back({3'd2, 16'h5678});
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_data[2*W +: W] !== 16'h5678) begin errors++; $display("FAIL stall_next: got %h required 5678", out_data[2*W +: W]); end
        tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain: %0d words pending required 0", exp_q.size()); end
    endtask

    task automatic test_flush();
        rr_mode   = 1'b0;
        out_ready = 8'h00;
        send(16'hAAAA, 3'd3);
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b required 1", busy); end
        if (out_valid !== 8'h08) begin errors++; $display("FAIL flush_valid_before: got %h required 08", out_valid); end
        flush     = 1'b1;
        out_ready = 8'hFF;
        in_data   = 16'h5555;
        in_valid  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b required 0", in_ready); end
        void'(exp_q.pop_back());
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 8'h00;
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b required 0", busy); end
        if (out_valid !== 8'h00) begin errors++; $display("FAIL flush_valid_after: got %h required 00", out_valid); end
        if (drop_count !== 8'd0) begin errors++; $display("FAIL flush_drop: got %0d required 0", drop_count); end
        tick();
    endtask

`ifdef DMUX_DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        rr_mode   = 1'b0;
        out_ready = 8'h00;
        for (int r = 0; r < 300; r++) begin
            if (r == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL to_in_ready: got %b required 1", in_ready); end
            end
            send(W'(r), 3'(r % 8));
            repeat (14) tick();
            if (r == 0) begin
                checks++;
                if (out_valid === 8'h00) begin errors++; $display("FAIL to_hold15: got out_valid=%h required nonzero", out_valid); end
            end
            tick();
            if (r == 0) begin
                checks += 4;
                if (out_valid !== 8'h00) begin errors++; $display("FAIL to_drop_valid: got %h required 00", out_valid); end
                if (busy !== 1'b1) begin errors++; $display("FAIL to_drop_busy: got %b required 1", busy); end
                if (in_ready !== 1'b0) begin errors++; $display("FAIL to_drop_ready: got %b required 0", in_ready); end
                if (drop_count !== 8'd1) begin errors++; $display("FAIL to_drop_count: got %0d required 1", drop_count); end
            end
            void'(exp_q.pop_back());
            tick();
        end
        checks++;
        if (drop_count !== 8'd255) begin errors++; $display("FAIL to_saturate: got %0d required 255", drop_count); end
    endtask
`else
    task automatic test_timeout();
        rr_mode   = 1'b0;
        out_ready = 8'h00;
        send(16'hC0DE, 3'd6);
        repeat (20) tick();
        checks += 3;
        if (busy !== 1'b1) begin errors++; $display("FAIL nto_busy: got %b required 1", busy); end
        if (out_valid !== 8'h40) begin errors++; $display("FAIL nto_valid: got %h required 40", out_valid); end
        if (drop_count !== 8'd0) begin errors++; $display("FAIL nto_drop: got %0d required 0", drop_count); end
        flush = 1'b1;
        void'(exp_q.pop_back());
        tick();
        flush = 1'b0;
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        rr_mode   = 1'b1;
        out_ready = 8'h00;
        send(16'h1111, 3'd0);
        tick();
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 8'h00) begin errors++; $display("FAIL rst_mid_valid: got %h required 00", out_valid); end
        if (out_data !== '0) begin errors++; $display("FAIL rst_mid_data: got %h required 0", out_data); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b required 0", busy); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b required 0", in_ready); end
        exp_q.delete();
        tb_ptr = 3'd0;
        tick();
        rst_n     = 1'b1;
        out_ready = 8'hFF;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready_after: got %b required 1", in_ready); end
        send(16'h2222, 3'd4);
        checks += 2;
        if (out_valid !== 8'h01) begin errors++; $display("FAIL rst_mid_rr_lane: got %h required 01", out_valid); end
        if (out_data[0 +: W] !== 16'h2222) begin errors++; $display("FAIL rst_mid_rr_data: got %h required 2222", out_data[0 +: W]); end
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_dest   = '0;
        in_valid  = 1'b0;
        rr_mode   = 1'b0;
        flush     = 1'b0;
        out_ready = 8'h00;
        tb_ptr    = 3'd0;

        test_reset();
        test_single();
        test_back_to_back_rr();
        test_stall();
        test_flush();
        test_timeout();
        test_reset_mid();

        tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL final_drain: %0d words pending required 0", exp_q.size()); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
